// File: rtl/serial_mag_comp_pkg.sv
// Shared definitions for the byte-serial magnitude comparator: FSM encoding,
// L/E/G flag-vector layout and the flag constants used by the cascade.
package serial_mag_comp_pkg;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_RESULT  = 1'b1
  } state_e;

  // Flag vector is {lt, eq, gt}
  localparam int FLAG_LT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_GT = 0;

  localparam logic [2:0] FLAGS_INIT = 3'b010;
  localparam logic [2:0] FLAGS_LT   = 3'b100;
  localparam logic [2:0] FLAGS_GT   = 3'b001;

  function automatic logic flags_decided(input logic [2:0] f);
    return f[FLAG_LT] | f[FLAG_GT];
  endfunction

endpackage

// File: rtl/serial_mag_comp_byte_cmp_step.sv
// One 8-bit stage of the L/E/G compare cascade: a decided verdict passes
// through untouched, otherwise this byte pair decides it.
module byte_cmp_step
  import serial_mag_comp_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] flags_in,
  output logic [2:0] flags_out
);

  always_comb begin
    flags_out = flags_in;
    if (!flags_decided(flags_in)) begin
      if (a > b)      flags_out = FLAGS_GT;
      else if (a < b) flags_out = FLAGS_LT;
      else            flags_out = FLAGS_INIT;
    end
  end

endmodule

// File: rtl/serial_mag_comp.sv
// Byte-serial unsigned magnitude comparator, MSB first. The registered flag
// vector is the cascade input to each following byte step.
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int CNT_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_gt,
  output logic [CNT_W-1:0] byte_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [2:0]       flags_q, flags_d;
  logic [2:0]       step_flags;
  logic             accept;

  byte_cmp_step u_step (
    .a         (in_a),
    .b         (in_b),
    .flags_in  (flags_q),
    .flags_out (step_flags)
  );

  assign in_ready  = (state_q == S_COLLECT);
  assign res_valid = (state_q == S_RESULT);
  assign accept    = in_valid && in_ready && !abort;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    flags_d = flags_q;
    unique case (state_q)
      S_COLLECT: begin
        if (abort) begin
          // Partial word discarded; any byte offered this cycle is dropped
          idx_d   = '0;
          flags_d = FLAGS_INIT;
        end else if (accept) begin
          flags_d = step_flags;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_RESULT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          state_d = S_COLLECT;
          flags_d = FLAGS_INIT;
        end
      end
      default: begin
        state_d = S_COLLECT;
        idx_d   = '0;
        flags_d = FLAGS_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_COLLECT;
      idx_q   <= '0;
      flags_q <= FLAGS_INIT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      flags_q <= flags_d;
    end
  end

  assign byte_idx = idx_q;
  assign res_lt   = flags_q[FLAG_LT];
  assign res_eq   = flags_q[FLAG_EQ];
  assign res_gt   = flags_q[FLAG_GT];

endmodule

// File: tb/tb_serial_mag_comp.sv
// Scoreboard bench for serial_mag_comp: word-level reference verdicts are
// queued at the last accept and popped by a monitor on each result handshake.
module tb_serial_mag_comp;

  localparam int NB = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_a = '0;
  logic [7:0]    in_b = '0;
  logic          res_valid;
  logic          res_ready;
  logic          res_lt, res_eq, res_gt;
  logic [CW-1:0] byte_idx;

  logic rr_rand = 1'b0;
  logic rr_man  = 1'b1;
  logic rr_rnd  = 1'b0;
  assign res_ready = rr_rand ? rr_rnd : rr_man;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] flg;
  assign flg = {res_lt, res_eq, res_gt};

  serial_mag_comp #(.NBYTES(NB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt), .byte_idx(byte_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference verdict from whole-word arithmetic, {lt,eq,gt}
  function automatic logic [2:0] ref_verdict(input logic [31:0] a, input logic [31:0] b);
    if (a < b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  always @(posedge clk) begin
    #1 rr_rnd = ($urandom_range(0, 3) != 0);
  end

  // Monitor: one-hot every cycle, verdict on every result handshake
  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot", {29'd0, flg}, {29'd0, ($onehot(flg) ? flg : 3'b000)});
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {29'd0, flg}, 32'hFFFF_FFFF);
        end else begin
          chk("verdict", {29'd0, flg}, {29'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] a, input logic [7:0] b, input int gap);
    logic acc;
    int   n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] b, input int maxgap);
    for (int i = 0; i < NB; i++)
      send_byte(a[8*(NB-1-i) +: 8], b[8*(NB-1-i) +: 8], $urandom_range(0, maxgap));
    exp_q.push_back(ref_verdict(a, b));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, b;
    int nb;

    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int nb;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_byte_idx", byte_idx, 0);
    chk("rst_flags", flg, 3'b010);
    @(posedge clk); #1;

    // Test 1: lt, no stalls, verdict the cycle after the last accept
    send_word(32'h4F00_0000, 32'h7800_0000, 0);
    @(negedge clk);
    chk("t1_res_valid", res_valid, 1);
    chk("t1_flags", flg, 3'b100);
    chk("t1_byte_idx", byte_idx, 0);
    @(posedge clk); #1;
    drain();

    // Test 2: gt decided on byte 0, later a<b bytes must not flip it
    send_byte(8'hCF, 8'h78, 0);
    @(negedge clk);
    chk("t2_early_gt", flg, 3'b001);
    chk("t2_idx1", byte_idx, 1);
    @(posedge clk); #1;
    send_byte(8'h12, 8'hFF, 0);
    send_byte(8'h34, 8'hFF, 0);
    @(negedge clk);
    chk("t2_no_result_yet", res_valid, 0);
    @(posedge clk); #1;
    send_byte(8'h56, 8'hFF, 0);
    exp_q.push_back(ref_verdict(32'hCF12_3456, 32'h78FF_FFFF));
    drain();

    // Test 3: equal, then lt decided on the last byte only
    send_word(32'hCFCF_CFCF, 32'hCFCF_CFCF, 1);
    send_word(32'hCFCF_CFCE, 32'hCFCF_CFCF, 1);
    drain();

    // Test 4: backpressure in RESULT with a byte offered
    rr_man = 1'b0;
    send_word(32'h0102_0304, 32'h0102_0300, 0);
    in_valid = 1'b1;
    in_a = 8'hAA;
    in_b = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_res_valid", res_valid, 1);
      chk("t4_flags", flg, 3'b001);
      chk("t4_byte_idx", byte_idx, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rr_man = 1'b1;
    drain();
    @(negedge clk);
    chk("t4_idx_after", byte_idx, 0);
    chk("t4_flags_after", flg, 3'b010);
    @(posedge clk); #1;
    send_word(32'h0000_0001, 32'h0000_0002, 0);
    drain();

    // Test 5: abort mid-word (gt so far), then fresh equal word; abort in RESULT
    send_byte(8'hF0, 8'h10, 0);
    send_byte(8'h00, 8'h00, 0);
    @(negedge clk);
    chk("t5_idx2", byte_idx, 2);
    @(posedge clk); #1;
    abort = 1'b1;
    in_valid = 1'b1;
    in_a = 8'hFF;
    in_b = 8'h00;
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_abort_idx", byte_idx, 0);
    chk("t5_abort_flags", flg, 3'b010);
    @(posedge clk); #1;
    send_word(32'h1234_5678, 32'h1234_5678, 0);
    drain();
    rr_man = 1'b0;
    send_word(32'h0000_0010, 32'h0000_0020, 0);
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("t5_result_abort_valid", res_valid, 1);
    chk("t5_result_abort_flags", flg, 3'b100);
    @(posedge clk); #1;
    rr_man = 1'b1;
    drain();

    // Test 6: reset mid-word and in RESULT
    send_byte(8'h01, 8'h02, 0);
    send_byte(8'h01, 8'h02, 0);
    send_byte(8'h01, 8'h02, 0);
    @(negedge clk);
    chk("t6_idx3", byte_idx, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_mid_valid", res_valid, 0);
    chk("t6_mid_idx", byte_idx, 0);
    chk("t6_mid_flags", flg, 3'b010);
    @(posedge clk); #1;
    rr_man = 1'b0;
    send_word(32'h9000_0000, 32'h1000_0000, 0);
    @(negedge clk);
    chk("t6_pre_valid", res_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rr_man = 1'b1;
    @(negedge clk);
    chk("t6_res_valid", res_valid, 0);
    chk("t6_res_idx", byte_idx, 0);
    chk("t6_res_flags", flg, 3'b010);
    @(posedge clk); #1;

    // Random words with input gaps, random res_ready and occasional aborts
    rr_rand = 1'b1;
    for (int w = 0; w < 60; w++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = {a[31:8], 8'($urandom)};
        2: b = {a[31:16], 16'($urandom)};
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        nb = $urandom_range(1, NB - 1);
        for (int i = 0; i < nb; i++)
          send_byte(a[8*(NB-1-i) +: 8], b[8*(NB-1-i) +: 8], $urandom_range(0, 2));
        abort = 1'b1;
        in_valid = 1'($urandom);
        @(posedge clk); #1;
        abort = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rnd_abort_idx", byte_idx, 0);
        @(posedge clk); #1;
      end else begin
        send_word(a, b, 2);
      end
    end
    rr_rand = 1'b0;
    rr_man = 1'b1;
    drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
